// File: rtl/mem_bridge_sequencer_if.sv
// Handshake and strobe bundle between the two requesters (pipeline memory
// stage and DMA engine), the memory device ready line, and the bridge
// sequencer that owns the MEM strobe group.
interface mem_bridge_sequencer_if;
    logic Pipe_Req;
    logic Pipe_Write;
    logic Dma_Req;
    logic Dma_Write;
    logic Mem_Ready;
    logic Pipe_Ack;
    logic Dma_Ack;
    logic Grant_Dma;
    logic Busy;
    logic Mem_Enable;
    logic MemBridge_Load;
    logic MemBridge_Assert;
    logic MemBridge_Direction;
    logic Timeout_Err;

    modport master (
        output Pipe_Req, Pipe_Write, Dma_Req, Dma_Write, Mem_Ready,
        input  Pipe_Ack, Dma_Ack, Grant_Dma, Busy, Mem_Enable,
        input  MemBridge_Load, MemBridge_Assert, MemBridge_Direction, Timeout_Err
    );

    modport slave (
        input  Pipe_Req, Pipe_Write, Dma_Req, Dma_Write, Mem_Ready,
        output Pipe_Ack, Dma_Ack, Grant_Dma, Busy, Mem_Enable,
        output MemBridge_Load, MemBridge_Assert, MemBridge_Direction, Timeout_Err
    );
endinterface

// File: rtl/mem_bridge_sequencer.sv
// Memory bridge sequencer: arbitrates the bridge between the pipeline memory
// stage and the DMA engine (round-robin on contention), walks each transfer
// through SETUP / WAIT / DONE, counts wait states against Mem_Ready, aborts
// on timeout, and pulses a one-cycle ack to the owner. Every output is decoded
// from registered state only, so there is no input-to-output combinational path.
module mem_bridge_sequencer #(
    parameter int WAIT_STATES = 1,
    parameter int TIMEOUT     = 15,
    parameter int CNT_W       = 4
) (
    input logic Clock_In,
    input logic Reset_In,
    mem_bridge_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] TOUT_LIM = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             owner;      // 1 = DMA owns the bridge, 0 = pipeline
    logic             last_owner; // owner of the most recently completed transfer
    logic             dir;        // 1 = write (bus -> memory)
    logic             err;

    logic [CNT_W-1:0] cnt_next;
    logic             pick_dma;

    // Wait count after this WAIT cycle; cnt never exceeds TIMEOUT-1 so no wrap.
    assign cnt_next = cnt + CNT_W'(1);

    // DMA wins when it is the only requester, or on contention when the
    // pipeline had the last turn.
    assign pick_dma = bus.Dma_Req & (~bus.Pipe_Req | ~last_owner);

    // Sequencer state, owner/direction latch, wait counter and abort flag.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            dir        <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Pipe_Req || bus.Dma_Req) begin
                        owner <= pick_dma;
                        dir   <= pick_dma ? bus.Dma_Write : bus.Pipe_Write;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt_next;
                    if ((cnt_next >= WAIT_LIM) && bus.Mem_Ready) begin
                        err   <= 1'b0;
                        state <= S_DONE;
                    end else if (cnt_next == TOUT_LIM) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_owner <= owner;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy                = (state != S_IDLE);
    assign bus.Grant_Dma           = (state != S_IDLE) & owner;
    assign bus.Mem_Enable          = (state == S_SETUP) | (state == S_WAIT);
    assign bus.MemBridge_Direction = (state != S_IDLE) & dir;
    assign bus.MemBridge_Load      = (state == S_SETUP) & dir;
    assign bus.MemBridge_Assert    = (state == S_DONE) & ~dir;
    assign bus.Pipe_Ack            = (state == S_DONE) & ~owner;
    assign bus.Dma_Ack             = (state == S_DONE) & owner;
    assign bus.Timeout_Err         = (state == S_DONE) & err;

endmodule

// File: tb/tb_mem_bridge_sequencer.sv
// Directed bench for mem_bridge_sequencer: pipeline write, DMA read with
// delayed ready, alternating arbitration, timeout abort, reset mid-transfer,
// and a WAIT_STATES=3 instance. Expected acks are queued when a request is
// launched and matched against the DUT when an ack appears.
module tb_mem_bridge_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    typedef struct {
        bit inst;   // 0 = main instance, 1 = WAIT_STATES=3 instance
        bit dma;
        bit err;
        int due;
    } exp_t;

    exp_t sb[$];

    mem_bridge_sequencer_if b();
    mem_bridge_sequencer_if b3();

    mem_bridge_sequencer #(.WAIT_STATES(1), .TIMEOUT(15), .CNT_W(4)) u_dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (b)
    );

    mem_bridge_sequencer #(.WAIT_STATES(3), .TIMEOUT(15), .CNT_W(4)) u_dut3 (
        .Clock_In (clk),
        .Reset_In (rst),
        .bus      (b3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs(input bit inst);
        if (inst)
            return {b3.Pipe_Ack, b3.Dma_Ack, b3.Grant_Dma, b3.Busy, b3.Mem_Enable,
                    b3.MemBridge_Load, b3.MemBridge_Assert, b3.MemBridge_Direction, b3.Timeout_Err};
        return {b.Pipe_Ack, b.Dma_Ack, b.Grant_Dma, b.Busy, b.Mem_Enable,
                b.MemBridge_Load, b.MemBridge_Assert, b.MemBridge_Direction, b.Timeout_Err};
    endfunction

    function automatic logic ack_p(input bit inst);
        return inst ? b3.Pipe_Ack : b.Pipe_Ack;
    endfunction

    function automatic logic ack_d(input bit inst);
        return inst ? b3.Dma_Ack : b.Dma_Ack;
    endfunction

    function automatic logic terr(input bit inst);
        return inst ? b3.Timeout_Err : b.Timeout_Err;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("excl_load_assert", 32'(b.MemBridge_Load & b.MemBridge_Assert), 0);
        chk("excl_acks", 32'(b.Pipe_Ack & b.Dma_Ack), 0);
        chk("excl_load_assert3", 32'(b3.MemBridge_Load & b3.MemBridge_Assert), 0);
        chk("excl_acks3", 32'(b3.Pipe_Ack & b3.Dma_Ack), 0);
    endtask

    task automatic wait_ack(input bit inst, input int budget);
        exp_t e;
        bit   seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (ack_p(inst) || ack_d(inst)) seen = 1'b1;
        end
        chk("ack_seen", 32'(seen), 1);
        chk("sb_pending", 32'(sb.size() > 0), 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ack_inst", 32'(inst), 32'(e.inst));
            chk("ack_dma", 32'(ack_d(inst)), 32'(e.dma));
            chk("ack_pipe", 32'(ack_p(inst)), 32'(!e.dma));
            chk("ack_timeout_err", 32'(terr(inst)), 32'(e.err));
            chk("ack_cycle", 32'(cyc), 32'(e.due));
        end
    endtask

    initial begin
        b.Pipe_Req = 0;  b.Pipe_Write = 0;  b.Dma_Req = 0;  b.Dma_Write = 0;  b.Mem_Ready = 0;
        b3.Pipe_Req = 0; b3.Pipe_Write = 0; b3.Dma_Req = 0; b3.Dma_Write = 0; b3.Mem_Ready = 0;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(outs(0)), 0);
        chk("reset_outs3", 32'(outs(1)), 0);
        rst = 1'b0;
        step();
        chk("idle_outs", 32'(outs(0)), 0);

        // 1: pipeline write, ready high
        b.Pipe_Write = 1; b.Mem_Ready = 1; b.Pipe_Req = 1;
        cyc = 0;
        sb.push_back('{1'b0, 1'b0, 1'b0, 3});
        step();
        chk("t1_load", 32'(b.MemBridge_Load), 1);
        chk("t1_dir", 32'(b.MemBridge_Direction), 1);
        chk("t1_busy", 32'(b.Busy), 1);
        chk("t1_grant", 32'(b.Grant_Dma), 0);
        chk("t1_assert", 32'(b.MemBridge_Assert), 0);
        step();
        chk("t1_wait_en", 32'(b.Mem_Enable), 1);
        chk("t1_load_off", 32'(b.MemBridge_Load), 0);
        wait_ack(0, 10);
        chk("t1_assert_done", 32'(b.MemBridge_Assert), 0);
        chk("t1_busy_done", 32'(b.Busy), 1);
        chk("t1_en_done", 32'(b.Mem_Enable), 0);
        b.Pipe_Req = 0; b.Pipe_Write = 0;
        step();
        chk("t1_idle", 32'(outs(0)), 0);

        // 2: DMA read, ready low until cycle 4, req and write wiggle after grant
        b.Mem_Ready = 0; b.Dma_Write = 0; b.Dma_Req = 1;
        cyc = 0;
        sb.push_back('{1'b0, 1'b1, 1'b0, 5});
        step();
        chk("t2_grant", 32'(b.Grant_Dma), 1);
        chk("t2_dir", 32'(b.MemBridge_Direction), 0);
        chk("t2_load", 32'(b.MemBridge_Load), 0);
        b.Dma_Write = 1;
        step();
        chk("t2_en", 32'(b.Mem_Enable), 1);
        b.Dma_Req = 0;
        step();
        chk("t2_noack", 32'({b.Pipe_Ack, b.Dma_Ack}), 0);
        step();
        chk("t2_still_wait", 32'(b.Mem_Enable), 1);
        b.Mem_Ready = 1;
        wait_ack(0, 10);
        chk("t2_assert", 32'(b.MemBridge_Assert), 1);
        chk("t2_grant_done", 32'(b.Grant_Dma), 1);
        chk("t2_dir_done", 32'(b.MemBridge_Direction), 0);
        b.Dma_Write = 0;
        step();
        chk("t2_assert_off", 32'(b.MemBridge_Assert), 0);
        chk("t2_grant_off", 32'(b.Grant_Dma), 0);

        // 3: both requesters held from reset, ownership alternates
        rst = 1'b1;
        b.Pipe_Req = 1; b.Dma_Req = 1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        sb.push_back('{1'b0, 1'b0, 1'b0, 3});
        sb.push_back('{1'b0, 1'b1, 1'b0, 7});
        sb.push_back('{1'b0, 1'b0, 1'b0, 11});
        wait_ack(0, 10);
        wait_ack(0, 10);
        wait_ack(0, 10);
        b.Pipe_Req = 0; b.Dma_Req = 0;
        step();
        chk("t3_idle", 32'(b.Busy), 0);

        // 4: ready never comes, timeout abort
        b.Mem_Ready = 0; b.Pipe_Write = 0; b.Pipe_Req = 1;
        cyc = 0;
        sb.push_back('{1'b0, 1'b0, 1'b1, 17});
        wait_ack(0, 30);
        chk("t4_assert_on_abort", 32'(b.MemBridge_Assert), 1);
        b.Pipe_Req = 0;
        step();
        chk("t4_err_clear", 32'(b.Timeout_Err), 0);
        chk("t4_idle", 32'(b.Busy), 0);

        // 5: reset during WAIT, request still held afterwards
        b.Mem_Ready = 0; b.Pipe_Req = 1;
        cyc = 0;
        step();
        step();
        chk("t5_wait", 32'(b.Mem_Enable), 1);
        rst = 1'b1;
        #1;
        chk("t5_async", 32'(outs(0)), 0);
        step();
        chk("t5_held", 32'(outs(0)), 0);
        rst = 1'b0;
        b.Mem_Ready = 1;
        cyc = 0;
        sb.push_back('{1'b0, 1'b0, 1'b0, 3});
        step();
        chk("t5_setup", 32'({b.Busy, b.Mem_Enable}), 3);
        wait_ack(0, 10);
        b.Pipe_Req = 0;
        step();
        chk("t5_idle", 32'(b.Busy), 0);

        // 6: WAIT_STATES=3 instance, ready high throughout including SETUP
        b3.Mem_Ready = 1; b3.Pipe_Write = 1; b3.Pipe_Req = 1;
        cyc = 0;
        sb.push_back('{1'b1, 1'b0, 1'b0, 5});
        step();
        chk("t6_setup_load", 32'(b3.MemBridge_Load), 1);
        wait_ack(1, 10);
        b3.Pipe_Req = 0;
        step();
        chk("t6_idle", 32'(b3.Busy), 0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
